// File: rtl/ahb_ui_sequencer.sv
// ---------------------------------------------------------------------------
// ahb_ui_sequencer
//
// Command front-end for an AHB master's user interface (UI). Burst commands
// (base address, beat count, size, direction) arrive on one valid/ready port.
// Write data arrives on a second valid/ready stream and is buffered in a
// small FIFO. Every UI output is a register that only moves at a rising edge
// where the master asserts i_next.
//
// Ports:
//   i_hclk, i_hreset_n          clock, asynchronous active-low reset
//   i_cmd_*, o_cmd_ready        burst command port
//   i_wdata*, o_wdata_ready     write-data stream into the FIFO
//   i_next                      master's "UI may change" indication
//   o_data, o_dav               write data to the master and its valid flag
//   o_addr, o_size, o_min_len   burst attributes
//   o_wr, o_rd, o_cont          request strobes and continuation flag
//   o_busy                      burst in progress (exposes the FSM state)
//   o_done                      one-cycle pulse after a burst's last beat
//
// Handshake rule for both input ports: a transfer happens at a rising edge
// where valid and ready are both 1. Ready may depend combinationally on the
// current state and i_next; valid must not depend on ready.
// ---------------------------------------------------------------------------
module ahb_ui_sequencer #(
  parameter int DATA_WDT   = 32,
  parameter int BEAT_WDT   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [BEAT_WDT-1:0] i_cmd_len,
  input  logic [2:0]          i_cmd_size,
  input  logic                i_cmd_wr,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [DATA_WDT-1:0] i_wdata,
  input  logic                i_next,
  output logic [DATA_WDT-1:0] o_data,
  output logic                o_dav,
  output logic [31:0]         o_addr,
  output logic [2:0]          o_size,
  output logic                o_wr,
  output logic                o_rd,
  output logic [BEAT_WDT-1:0] o_min_len,
  output logic                o_cont,
  output logic                o_busy,
  output logic                o_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [BEAT_WDT-1:0] rem_q, rem_d;
  logic [DATA_WDT-1:0] data_q, data_d;
  logic                dav_q, dav_d;
  logic [31:0]         addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [BEAT_WDT-1:0] min_len_q, min_len_d;
  logic                cont_q, cont_d;
  logic                done_q, done_d;

  // Write-data FIFO: storage has no reset, pointers and count do.
  logic [DATA_WDT-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fifo_full, fifo_empty, push, pop;

  logic run, consumed, last, cmd_ready, accept;

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = i_wdata_valid & ~fifo_full;

  // A beat is taken by the master when a read is requested, or a write is
  // requested with valid data; only meaningful together with i_next.
  assign run       = (state_q == ST_RUN);
  assign consumed  = rd_q | (wr_q & dav_q);
  assign last      = run & consumed & (rem_q == BEAT_WDT'(1));
  assign cmd_ready = i_next & (~run | last);
  assign accept    = i_cmd_valid & cmd_ready;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    data_d    = data_q;
    dav_d     = dav_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    min_len_d = min_len_q;
    cont_d    = cont_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    if (i_next) begin
      // Finishing beat: drop to idle first; a same-edge command below
      // overrides these values so there is no idle gap.
      if (last) begin
        state_d = ST_IDLE;
        rem_d   = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        cont_d  = 1'b0;
        dav_d   = 1'b0;
        done_d  = 1'b1;
      end

      if (accept) begin
        if (i_cmd_len == '0) begin
          done_d = 1'b1;
        end else begin
          state_d   = ST_RUN;
          rem_d     = i_cmd_len;
          addr_d    = i_cmd_addr;
          size_d    = i_cmd_size;
          min_len_d = i_cmd_len;
          cont_d    = 1'b0;
          rd_d      = ~i_cmd_wr;
          wr_d      = i_cmd_wr;
          dav_d     = 1'b0;
          if (i_cmd_wr && !fifo_empty) begin
            pop    = 1'b1;
            data_d = mem[rptr_q];
            dav_d  = 1'b1;
          end
        end
      end else if (run && consumed && !last) begin
        rem_d  = rem_q - BEAT_WDT'(1);
        cont_d = 1'b1;
        if (wr_q) begin
          dav_d = 1'b0;
          if (!fifo_empty) begin
            pop    = 1'b1;
            data_d = mem[rptr_q];
            dav_d  = 1'b1;
          end
        end
      end else if (run && wr_q && !dav_q && !fifo_empty) begin
        // Write beat was starved: present the word as soon as it arrives.
        pop    = 1'b1;
        data_d = mem[rptr_q];
        dav_d  = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      data_q    <= '0;
      dav_q     <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      min_len_q <= '0;
      cont_q    <= 1'b0;
      done_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      dav_q     <= dav_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      min_len_q <= min_len_d;
      cont_q    <= cont_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_hclk) begin
    if (push) mem[wptr_q] <= i_wdata;
  end

  assign o_cmd_ready   = cmd_ready;
  assign o_wdata_ready = ~fifo_full;
  assign o_data        = data_q;
  assign o_dav         = dav_q;
  assign o_addr        = addr_q;
  assign o_size        = size_q;
  assign o_wr          = wr_q;
  assign o_rd          = rd_q;
  assign o_min_len     = min_len_q;
  assign o_cont        = cont_q;
  assign o_busy        = run;
  assign o_done        = done_q;

endmodule
